biriscv_v_alu_pipe: RTL and testbench
=====================================

// Module: biriscv_v_alu_pipe
// PURPOSE
//  Multi-cycle vector integer ALU for the biRISC-V vector unit. Supports SEW=8/16/32, vl-limited bodies,
//  RVV mask layout (mask bit i -> element i) and mask/tail-undisturbed writeback.
//  Operates on LANE_W bits per cycle.
//  Sits between vector issue (operands already read from VRF) and VRF writeback, with a valid/ready on each side.
// PARAMETERS
//  VLEN    128  vector register width in bits; a multiple of LANE_W
//  LANE_W  64   datapath bits processed per beat; a multiple of 32; BEATS = VLEN/LANE_W
//  ELEN    32   maximum element width; SEW > ELEN is illegal
// PORTS
//  clk_i           in   1        clock
//  rst_ni          in   1        reset, synchronous, active-low
//  req_valid_i     in   1        request valid
//  req_ready_o     out  1        block idle, can accept a request
//  req_op_i        in   4        0 ADD, 1 SUB, 2 RSUB, 3 MINU, 4 MAXU, 5 MIN, 6 MAX, 7 AND, 8 OR, 9 XOR; others illegal
//  req_src_i       in   2        operand-B source: 0 VV (req_vb_i), 1 VX (req_scalar_i), 2 VI (req_imm_i); 3 illegal
//  req_sew_i       in   2        0 = 8b, 1 = 16b, 2 = 32b, 3 = illegal
//  req_vm_i        in   1        1 = unmasked; 0 = element i active only if req_vmask_i[i]
//  req_vl_i        in   $clog2(VLEN/8)+1  active element count
//  req_va_i        in   VLEN     vs2 operand
//  req_vb_i        in   VLEN     vs1 operand
//  req_scalar_i    in   32       rs1 value
//  req_imm_i       in   5        simm5
//  req_vd_old_i    in   VLEN     previous vd contents, used for undisturbed elements
//  req_vmask_i     in   VLEN     v0 contents
//  req_vd_idx_i    in   5        destination register index, returned with the result
//  resp_valid_o    out  1        result valid
//  resp_ready_i    in   1        writeback accepts the result
//  resp_result_o   out  VLEN     result vector
//  resp_vd_idx_o   out  5        destination register index
//  resp_illegal_o  out  1        the request had an illegal op, src or sew
// BEHAVIOUR
//  FSM states
//   - IDLE -> EXEC on req_valid_i & req_ready_o.
//   - EXEC -> DONE after beat BEATS-1.
//   - DONE -> IDLE on resp_valid_o & resp_ready_i.
//   - req_ready_o = (state == IDLE). req_ready_o does not depend combinationally on req_valid_i.
//  Request capture
//   - All req_* inputs are captured at accept. The inputs may change freely afterwards.
//  Beat counter
//   - beat runs 0..BEATS-1 in EXEC.
//   - Each beat computes and writes bits [beat*LANE_W +: LANE_W] of the result register.
//  Latency
//   - Request accepted at the edge ending cycle N.
//   - Beats occupy cycles N+1 .. N+BEATS.
//   - resp_valid_o is high from cycle N+BEATS+1 and held with stable outputs until resp_ready_i.
//   - Minimum request-to-request spacing is BEATS+2 cycles.
//  Element index and activity
//   - Element index e = bit_position / SEW.
//   - vl_eff = min(req_vl_i, VLEN/SEW).
//   - Element e is active iff e < vl_eff && (vm || vmask[e]).
//  Result per element
//   - Active element: computed value.
//   - Inactive element, or tail element (e >= vl_eff): vd_old element. This is undisturbed policy.
//  Operand B
//   - VX: scalar[SEW-1:0].
//   - VI: simm5 sign-extended to SEW.
//  Arithmetic
//   - All arithmetic is modulo 2^SEW with no saturation.
//   - SUB = va - b. RSUB = b - va.
//   - MINU/MAXU compare unsigned. MIN/MAX compare SEW-bit two's complement.
//  Illegal request
//   - Illegal op, src or sew: still takes BEATS cycles.
//   - Result = vd_old, resp_illegal_o = 1.
//  vl = 0
//   - Result = vd_old, normal latency, resp_illegal_o = 0.
//  Reset (rst_ni low at a clock edge)
//   - state = IDLE, beat = 0.
//   - resp_valid_o = 0, resp_result_o = 0, resp_vd_idx_o = 0, resp_illegal_o = 0.
//   - req_ready_o = 0 while rst_ni is low and 1 from the first cycle after release.
//   - Reset mid-EXEC or mid-DONE aborts the operation; no response is produced.
// TESTING
//  1. VLEN=128, LANE_W=64, SEW=32, ADD VV, vm=1, vl=4, va={4,3,2,1}, vb={10,10,10,10}
//     -> {14,13,12,11}; resp_valid_o 3 cycles after accept.
//  2. SEW=8, VI ADD, imm=5'h1F, va all 8'h00, vl=16, vm=1 -> all bytes 8'hFF (imm sign-extended to -1).
//  3. SEW=16, SUB VX, scalar=32'h0001_0003, va elements = 16'h0002 -> 16'hFFFF (wrap; upper scalar bits ignored).
//  4. SEW=32, vm=0, v0=4'b0101, vl=3, vd_old={D,C,B,A}, MAXU VV -> elements 0 and 2 computed,
//     element 1 = B, element 3 = D.
//  5. MIN vs MINU on 8'h80 vs 8'h01: MIN -> 8'h80, MINU -> 8'h01.
//     sew=3 -> resp_illegal_o=1, result = vd_old.
//  6. Handshake and reset:
//     - resp_ready_i held low 5 cycles -> outputs stable, req_ready_o=0.
//     - rst_ni low during EXEC -> resp_valid_o never rises; req_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/biriscv_v_alu_pipe.sv
// Multi-cycle vector integer ALU: processes LANE_W bits of a VLEN-bit vector per beat,
// applying vl, the v0 mask and undisturbed writeback for inactive and tail elements.
module biriscv_v_alu_pipe #(
  parameter int VLEN   = 128,
  parameter int LANE_W = 64,
  parameter int ELEN   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [3:0]                 req_op_i,
  input  logic [1:0]                 req_src_i,
  input  logic [1:0]                 req_sew_i,
  input  logic                       req_vm_i,
  input  logic [$clog2(VLEN/8):0]    req_vl_i,
  input  logic [VLEN-1:0]            req_va_i,
  input  logic [VLEN-1:0]            req_vb_i,
  input  logic [31:0]                req_scalar_i,
  input  logic [4:0]                 req_imm_i,
  input  logic [VLEN-1:0]            req_vd_old_i,
  input  logic [VLEN-1:0]            req_vmask_i,
  input  logic [4:0]                 req_vd_idx_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [VLEN-1:0]            resp_result_o,
  output logic [4:0]                 resp_vd_idx_o,
  output logic                       resp_illegal_o
);

  localparam int BEATS = VLEN / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VLW   = $clog2(VLEN/8) + 1;
  localparam int LB    = LANE_W / 8;
  localparam int LH    = LANE_W / 16;
  localparam int LW    = LANE_W / 32;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_RSUB, OP_MINU, OP_MAXU, OP_MIN, OP_MAX, OP_AND, OP_OR, OP_XOR
  } op_e;
  typedef enum logic [1:0] {SRC_VV, SRC_VX, SRC_VI} src_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q;
  logic [VLEN-1:0]   res_q;
  logic [4:0]        vd_idx_q;
  logic              illegal_q;

  logic [3:0]        op_q;
  logic [1:0]        src_q, sew_q;
  logic              vm_q;
  logic [VLW-1:0]    vl_q;
  logic [VLEN-1:0]   va_q, vb_q, vd_old_q;
  logic [VLEN/8-1:0] vmask_q;
  logic [31:0]       scalar_q;
  logic [4:0]        imm_q;

  logic accept, illegal_req, last_beat;
  // Only the first VLEN/8 mask bits can ever address an element.
  logic unused_mask;
  assign unused_mask = ^req_vmask_i[VLEN-1:VLEN/8];

  assign req_ready_o = rst_ni && (state_q == S_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign last_beat   = (beat_q == BW'(BEATS - 1));
  assign illegal_req = (req_op_i > OP_XOR) || (req_src_i == 2'd3) || (req_sew_i == 2'd3) ||
                       ((32'd8 << req_sew_i) > ELEN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)       state_d = S_EXEC;
      S_EXEC:  if (last_beat)    state_d = S_DONE;
      S_DONE:  if (resp_ready_i) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: captured operands carry no reset; they are only consumed after an accept loads them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q     <= req_op_i;
      src_q    <= req_src_i;
      sew_q    <= req_sew_i;
      vm_q     <= req_vm_i;
      vl_q     <= req_vl_i;
      va_q     <= req_va_i;
      vb_q     <= req_vb_i;
      vd_old_q <= req_vd_old_i;
      vmask_q  <= req_vmask_i[VLEN/8-1:0];
      scalar_q <= req_scalar_i;
      imm_q    <= req_imm_i;
    end
  end

  // Element computation on zero-extended operands; the caller truncates to SEW.
  function automatic logic [31:0] elem_op(input logic [3:0] op, input logic [1:0] sew,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] as, bs;
    logic        lt_u, lt_s;
    case (sew)
      2'd0:    begin as = {{24{a[7]}},  a[7:0]};  bs = {{24{b[7]}},  b[7:0]};  end
      2'd1:    begin as = {{16{b[15]&1'b0 | a[15]}}, a[15:0]}; bs = {{16{b[15]}}, b[15:0]}; end
      default: begin as = a;                      bs = b;                      end
    endcase
    lt_u = a < b;
    lt_s = $signed(as) < $signed(bs);
    case (op)
      OP_ADD:  elem_op = a + b;
      OP_SUB:  elem_op = a - b;
      OP_RSUB: elem_op = b - a;
      OP_MINU: elem_op = lt_u ? a : b;
      OP_MAXU: elem_op = lt_u ? b : a;
      OP_MIN:  elem_op = lt_s ? a : b;
      OP_MAX:  elem_op = lt_s ? b : a;
      OP_AND:  elem_op = a & b;
      OP_OR:   elem_op = a | b;
      OP_XOR:  elem_op = a ^ b;
      default: elem_op = a;
    endcase
  endfunction

  logic [31:0]       shamt, b_scalar;
  logic [LANE_W-1:0] lane_va, lane_vb, lane_old, lane_res, res8, res16, res32;
  logic [LB-1:0]     m8;
  logic [LH-1:0]     m16;
  logic [LW-1:0]     m32;
  logic [VLEN-1:0]   lane_sel;

  assign shamt    = 32'(beat_q) * LANE_W;
  assign lane_va  = LANE_W'(va_q >> shamt);
  assign lane_vb  = LANE_W'(vb_q >> shamt);
  assign lane_old = LANE_W'(vd_old_q >> shamt);
  assign m8       = LB'(vmask_q >> (32'(beat_q) * LB));
  assign m16      = LH'(vmask_q >> (32'(beat_q) * LH));
  assign m32      = LW'(vmask_q >> (32'(beat_q) * LW));
  assign b_scalar = (src_q == SRC_VI) ? {{27{imm_q[4]}}, imm_q} : scalar_q;
  assign lane_sel = VLEN'({LANE_W{1'b1}}) << shamt;

  // Element indices never exceed VLEN/SEW-1, so e < vl is the same test as e < min(vl, VLEN/SEW).
  for (genvar g = 0; g < LB; g++) begin : g_e8
    logic act;
    assign act = ((32'(beat_q) * LB + 32'(g)) < 32'(vl_q)) && (vm_q || m8[g]);
    assign res8[g*8 +: 8] = act ?
      8'(elem_op(op_q, sew_q, 32'(lane_va[g*8 +: 8]),
                 (src_q == SRC_VV) ? 32'(lane_vb[g*8 +: 8]) : 32'(b_scalar[7:0])))
      : lane_old[g*8 +: 8];
  end

  for (genvar g = 0; g < LH; g++) begin : g_e16
    logic act;
    assign act = ((32'(beat_q) * LH + 32'(g)) < 32'(vl_q)) && (vm_q || m16[g]);
    assign res16[g*16 +: 16] = act ?
      16'(elem_op(op_q, sew_q, 32'(lane_va[g*16 +: 16]),
                  (src_q == SRC_VV) ? 32'(lane_vb[g*16 +: 16]) : 32'(b_scalar[15:0])))
      : lane_old[g*16 +: 16];
  end

  for (genvar g = 0; g < LW; g++) begin : g_e32
    logic act;
    assign act = ((32'(beat_q) * LW + 32'(g)) < 32'(vl_q)) && (vm_q || m32[g]);
    assign res32[g*32 +: 32] = act ?
      elem_op(op_q, sew_q, lane_va[g*32 +: 32],
              (src_q == SRC_VV) ? lane_vb[g*32 +: 32] : b_scalar)
      : lane_old[g*32 +: 32];
  end

  always_comb begin
    lane_res = lane_old;
    if (!illegal_q) begin
      case (sew_q)
        2'd0:    lane_res = res8;
        2'd1:    lane_res = res16;
        2'd2:    lane_res = res32;
        default: lane_res = lane_old;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q    <= '0;
      res_q     <= '0;
      vd_idx_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      beat_q    <= '0;
      vd_idx_q  <= req_vd_idx_i;
      illegal_q <= illegal_req;
    end else if (state_q == S_EXEC) begin
      res_q  <= (res_q & ~lane_sel) | (VLEN'(lane_res) << shamt);
      beat_q <= last_beat ? '0 : beat_q + 1'b1;
    end
  end

  assign resp_valid_o   = (state_q == S_DONE);
  assign resp_result_o  = res_q;
  assign resp_vd_idx_o  = vd_idx_q;
  assign resp_illegal_o = illegal_q;

endmodule

// File: tb/tb_biriscv_v_alu_pipe.sv
// Scoreboard bench for biriscv_v_alu_pipe: directed cases with hand-derived results plus
// randomized requests checked against an element-by-element reference model.
module tb_biriscv_v_alu_pipe;
  localparam int VLEN   = 128;
  localparam int LANE_W = 64;
  localparam int BEATS  = VLEN / LANE_W;
  localparam int VLW    = $clog2(VLEN/8) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [3:0]       req_op = '0;
  logic [1:0]       req_src = '0, req_sew = '0;
  logic             req_vm = 1'b1;
  logic [VLW-1:0]   req_vl = '0;
  logic [VLEN-1:0]  req_va = '0, req_vb = '0, req_vd_old = '0, req_vmask = '0;
  logic [31:0]      req_scalar = '0;
  logic [4:0]       req_imm = '0, req_vd_idx = '0;
  logic             resp_valid, resp_ready = 1'b0, resp_illegal;
  logic [VLEN-1:0]  resp_result;
  logic [4:0]       resp_vd_idx;

  typedef struct {
    logic [3:0] op; logic [1:0] src; logic [1:0] sew; logic vm; logic [VLW-1:0] vl;
    logic [VLEN-1:0] va; logic [VLEN-1:0] vb; logic [VLEN-1:0] vd_old; logic [VLEN-1:0] vmask;
    logic [31:0] scalar; logic [4:0] imm; logic [4:0] vd_idx;
  } req_t;
  typedef struct { logic [VLEN-1:0] res; logic [4:0] vd; logic ill; } exp_t;

  exp_t scb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, acc_cyc = 0;

  biriscv_v_alu_pipe #(.VLEN(VLEN), .LANE_W(LANE_W), .ELEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_src_i(req_src), .req_sew_i(req_sew), .req_vm_i(req_vm),
    .req_vl_i(req_vl), .req_va_i(req_va), .req_vb_i(req_vb), .req_scalar_i(req_scalar),
    .req_imm_i(req_imm), .req_vd_old_i(req_vd_old), .req_vmask_i(req_vmask),
    .req_vd_idx_i(req_vd_idx),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
    .resp_vd_idx_o(resp_vd_idx), .resp_illegal_o(resp_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VLEN-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op = 4'($urandom_range(0, 9)); r.src = 2'($urandom_range(0, 2));
    r.sew = 2'($urandom_range(0, 2)); r.vm = 1'($urandom_range(0, 1));
    r.vl = VLW'($urandom_range(0, 16)); r.va = rnd_vec(); r.vb = rnd_vec();
    r.vd_old = rnd_vec(); r.vmask = rnd_vec(); r.scalar = $urandom;
    r.imm = 5'($urandom); r.vd_idx = 5'($urandom);
    return r;
  endfunction

  // Reference: walk elements one bit at a time in 64-bit arithmetic.
  function automatic exp_t model(req_t r);
    exp_t x; int sew, nel, vle; longint msk, a, b, v, sa, sbv, si;
    x.res = r.vd_old; x.vd = r.vd_idx;
    x.ill = (r.op > 4'd9) || (r.src == 2'd3) || (r.sew == 2'd3);
    if (x.ill) return x;
    sew = 8 << r.sew; nel = VLEN / sew;
    vle = (int'(r.vl) < nel) ? int'(r.vl) : nel;
    msk = (64'sd1 << sew) - 1;
    for (int e = 0; e < vle; e++) begin
      if (r.vm || r.vmask[e]) begin
        a = 0; b = 0;
        for (int k = 0; k < sew; k++) begin a[k] = r.va[e*sew+k]; b[k] = r.vb[e*sew+k]; end
        if (r.src == 2'd1) b = longint'(r.scalar) & msk;
        if (r.src == 2'd2) begin si = $signed(r.imm); b = si & msk; end
        sa  = a[sew-1] ? a - (msk + 1) : a;
        sbv = b[sew-1] ? b - (msk + 1) : b;
        case (r.op)
          4'd0: v = a + b;          4'd1: v = a - b;          4'd2: v = b - a;
          4'd3: v = (a < b) ? a : b; 4'd4: v = (a > b) ? a : b;
          4'd5: v = (sa < sbv) ? a : b; 4'd6: v = (sa > sbv) ? a : b;
          4'd7: v = a & b;          4'd8: v = a | b;          default: v = a ^ b;
        endcase
        v = v & msk;
        for (int k = 0; k < sew; k++) x.res[e*sew+k] = v[k];
      end
    end
    return x;
  endfunction

  task automatic send(input req_t r);
    int t = 0;
    @(negedge clk);
    req_op = r.op; req_src = r.src; req_sew = r.sew; req_vm = r.vm; req_vl = r.vl;
    req_va = r.va; req_vb = r.vb; req_vd_old = r.vd_old; req_vmask = r.vmask;
    req_scalar = r.scalar; req_imm = r.imm; req_vd_idx = r.vd_idx; req_valid = 1'b1;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready_o=%b required 1", req_ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_va = rnd_vec(); req_vb = rnd_vec(); req_vd_old = rnd_vec(); req_vmask = rnd_vec();
    req_op = 4'($urandom); req_sew = 2'($urandom); req_vl = VLW'($urandom);
    req_scalar = $urandom; req_imm = 5'($urandom); req_vd_idx = 5'($urandom);
  endtask

  task automatic collect(input string name, input int stall, output int lat);
    int t = 0; exp_t x;
    resp_ready = 1'b0;
    @(negedge clk);
    while (!resp_valid && t < 50) begin @(negedge clk); t++; end
    lat = cyc - acc_cyc;
    n_vec++;
    if (!resp_valid) begin
      n_err++; $display("FAIL %s_valid_timeout: resp_valid_o=%b required 1", name, resp_valid);
    end
    x = (scb.size() > 0) ? scb.pop_front() : '{res: '0, vd: '0, ill: 1'b0};
    for (int s = 0; s < stall; s++) begin
      n_vec++;
      if (resp_valid !== 1'b1 || resp_result !== x.res || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s_stall%0d: valid=%b ready=%b result=%h required valid=1 ready=0 result=%h",
                 name, s, resp_valid, req_ready, resp_result, x.res);
      end
      @(negedge clk);
    end
    n_vec++;
    if (resp_result !== x.res || resp_vd_idx !== x.vd || resp_illegal !== x.ill) begin
      n_err++;
      $display("FAIL %s: result=%h vd=%0d ill=%b required result=%h vd=%0d ill=%b",
               name, resp_result, resp_vd_idx, resp_illegal, x.res, x.vd, x.ill);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_result !== '0 ||
        resp_vd_idx !== 5'd0 || resp_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h vd=%0d ill=%b required all 0",
               req_ready, resp_valid, resp_result, resp_vd_idx, resp_illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_add_vv();
    req_t r; int lat;
    r = rand_req();
    r.op = 4'd0; r.src = 2'd0; r.sew = 2'd2; r.vm = 1'b1; r.vl = VLW'(4); r.vd_idx = 5'd3;
    r.va = {32'd4, 32'd3, 32'd2, 32'd1}; r.vb = {4{32'd10}};
    scb.push_back('{res: {32'd14, 32'd13, 32'd12, 32'd11}, vd: 5'd3, ill: 1'b0});
    send(r);
    collect("add_vv_sew32", 0, lat);
    n_vec++;
    if (lat !== BEATS + 1) begin
      n_err++; $display("FAIL add_vv_latency: got %0d cycles required %0d", lat, BEATS + 1);
    end
  endtask

  task automatic test_operand_sources();
    req_t r; int lat;
    r = rand_req();
    r.op = 4'd0; r.src = 2'd2; r.sew = 2'd0; r.vm = 1'b1; r.vl = VLW'(16);
    r.imm = 5'h1F; r.va = '0; r.vd_idx = 5'd7;
    scb.push_back('{res: {16{8'hFF}}, vd: 5'd7, ill: 1'b0});
    send(r); collect("vi_add_sew8", 0, lat);
    r = rand_req();
    r.op = 4'd1; r.src = 2'd1; r.sew = 2'd1; r.vm = 1'b1; r.vl = VLW'(8);
    r.scalar = 32'h0001_0003; r.va = {8{16'h0002}}; r.vd_idx = 5'd9;
    scb.push_back('{res: {8{16'hFFFF}}, vd: 5'd9, ill: 1'b0});
    send(r); collect("vx_sub_sew16", 0, lat);
  endtask

  task automatic test_masked_tail();
    req_t r; int lat;
    r = rand_req();
    r.op = 4'd4; r.src = 2'd0; r.sew = 2'd2; r.vm = 1'b0; r.vl = VLW'(3);
    r.vmask = 128'h5; r.vd_idx = 5'd1;
    r.vd_old = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    r.va = {32'd1, 32'd50, 32'd7, 32'd9}; r.vb = {32'd2, 32'd3, 32'd100, 32'd4};
    scb.push_back('{res: {32'hDDDD_DDDD, 32'd50, 32'hBBBB_BBBB, 32'd9}, vd: 5'd1, ill: 1'b0});
    send(r); collect("masked_maxu", 0, lat);
  endtask

  task automatic test_min_minu();
    req_t r; int lat;
    r = rand_req();
    r.src = 2'd0; r.sew = 2'd0; r.vm = 1'b1; r.vl = VLW'(16);
    r.va = {16{8'h80}}; r.vb = {16{8'h01}}; r.vd_idx = 5'd4;
    r.op = 4'd5;
    scb.push_back('{res: {16{8'h80}}, vd: 5'd4, ill: 1'b0});
    send(r); collect("min_signed", 0, lat);
    r.op = 4'd3;
    scb.push_back('{res: {16{8'h01}}, vd: 5'd4, ill: 1'b0});
    send(r); collect("minu_unsigned", 0, lat);
  endtask

  task automatic test_illegal_and_vl0();
    req_t r; int lat;
    r = rand_req(); r.sew = 2'd3;
    scb.push_back('{res: r.vd_old, vd: r.vd_idx, ill: 1'b1});
    send(r); collect("illegal_sew", 0, lat);
    n_vec++;
    if (lat !== BEATS + 1) begin
      n_err++; $display("FAIL illegal_latency: got %0d cycles required %0d", lat, BEATS + 1);
    end
    r = rand_req(); r.op = 4'd12;
    scb.push_back('{res: r.vd_old, vd: r.vd_idx, ill: 1'b1});
    send(r); collect("illegal_op", 0, lat);
    r = rand_req(); r.src = 2'd3;
    scb.push_back('{res: r.vd_old, vd: r.vd_idx, ill: 1'b1});
    send(r); collect("illegal_src", 0, lat);
    r = rand_req(); r.vl = '0; r.vm = 1'b1;
    scb.push_back('{res: r.vd_old, vd: r.vd_idx, ill: 1'b0});
    send(r); collect("vl_zero", 0, lat);
    r = rand_req(); r.op = 4'd9; r.sew = 2'd2; r.vl = VLW'(16); r.vm = 1'b1;
    scb.push_back('{res: r.va ^ (r.src == 2'd0 ? r.vb :
                   r.src == 2'd1 ? {4{r.scalar}} : {4{{27{r.imm[4]}}, r.imm}}),
                   vd: r.vd_idx, ill: 1'b0});
    send(r); collect("vl_clamp_xor", 0, lat);
  endtask

  task automatic test_back_to_back();
    req_t r; int lat, prev;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      r = rand_req();
      scb.push_back(model(r));
      send(r);
      if (prev >= 0) begin
        n_vec++;
        if (acc_cyc - prev !== BEATS + 2) begin
          n_err++;
          $display("FAIL b2b_spacing: got %0d cycles required %0d", acc_cyc - prev, BEATS + 2);
        end
      end
      prev = acc_cyc;
      collect("b2b", 0, lat);
    end
  endtask

  task automatic test_stall();
    req_t r; int lat;
    r = rand_req();
    scb.push_back(model(r));
    send(r); collect("stall", 5, lat);
  endtask

  task automatic test_random();
    req_t r; int lat;
    for (int i = 0; i < 24; i++) begin
      r = rand_req();
      scb.push_back(model(r));
      send(r); collect("random", 0, lat);
    end
  endtask

  task automatic test_reset_mid_exec();
    req_t r; int seen;
    r = rand_req();
    send(r);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_hold: ready=%b valid=%b required 0 0", req_ready, resp_valid);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_ready: got %b required 1", req_ready);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (resp_valid) seen++; end
    n_vec++;
    if (seen != 0 || resp_result !== '0) begin
      n_err++;
      $display("FAIL midreset_no_resp: valid seen %0d times, result=%h required 0", seen, resp_result);
    end
  endtask

  initial begin
    test_reset();
    test_add_vv();
    test_operand_sources();
    test_masked_tail();
    test_min_minu();
    test_illegal_and_vl0();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid_exec();
    test_add_vv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
